qam_frame_scheduler: RTL and testbench

// - Frame-level controller for the LFSR -> QAM mapper transmit datapath.
// - One start command runs one frame: seed load, fixed preamble, LEN payload symbols, flush, done.
// - Drives lfsr_seed/lfsr_load and the datapath enables. Counts valid_out pulses from the mapper.
// - Watchdog aborts a frame if the mapper stalls.

---
 rtl/qam_ctrl_pkg.sv | 21 ++
 rtl/qam_watchdog_cnt.sv | 32 +++
 rtl/qam_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_qam_frame_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qam_ctrl_pkg.sv
// Shared types and defaults for the QAM transmit frame controller.
// Holds the controller state encoding and the default datapath geometry.
package qam_ctrl_pkg;

  localparam int SEED_W       = 7;
  localparam int PRE_LEN      = 8;
  localparam int FLUSH_CYCLES = 4;

  // An all-zero seed locks the LFSR, so it is replaced by this value on latch.
  localparam int SEED_NONZERO = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    PAY,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/qam_watchdog_cnt.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th consecutive one as expired.
module qam_watchdog_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/qam_frame_scheduler.sv
// Frame controller for the LFSR -> QAM mapper datapath: seed load, preamble,
// payload, flush and done, with software abort and a payload stall watchdog.
module qam_frame_scheduler #(
  parameter int SEED_W       = qam_ctrl_pkg::SEED_W,
  parameter int LEN_W        = 10,
  parameter int PRE_LEN      = qam_ctrl_pkg::PRE_LEN,
  parameter int FLUSH_CYCLES = qam_ctrl_pkg::FLUSH_CYCLES,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              dp_valid,
  output logic [SEED_W-1:0] lfsr_seed,
  output logic              lfsr_load,
  output logic              dp_enable,
  output logic              sel_preamble,
  output logic              dp_flush,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              aborted,
  output logic [LEN_W-1:0]  sym_count
);

  import qam_ctrl_pkg::*;

  localparam int PH_MAX = (PRE_LEN > FLUSH_CYCLES) ? PRE_LEN : FLUSH_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PRE_LAST   = PH_W'(PRE_LEN - 1);
  localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_CYCLES - 1);

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase;
  logic [LEN_W-1:0]  len_q;
  logic              accept;
  logic              abort_live;
  logic              pay_complete;
  logic              wd_expired;

  assign accept       = (state == IDLE) && start;
  assign abort_live   = abort && (state == PRE || state == PAY || state == FLUSH);
  assign pay_complete = dp_valid && (sym_count + 1'b1 == len_q);

  qam_watchdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state != PAY) || dp_valid),
    .enable  ((state == PAY) && !dp_valid),
    .expired (wd_expired)
  );

  // NOTE: the next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = PRE;
      PRE: begin
        if (abort)                  state_nxt = FLUSH;
        else if (phase == PRE_LAST) state_nxt = (len_q == '0) ? FLUSH : PAY;
      end
      PAY:   if (abort || wd_expired || pay_complete) state_nxt = FLUSH;
      FLUSH: if (phase == FLUSH_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      // Phase restarts on every state change, so it counts cycles within PRE/FLUSH.
      if (state_nxt != state || (state != PRE && state != FLUSH)) phase <= '0;
      else                                                        phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      lfsr_seed <= '0;
    end else if (accept) begin
      len_q     <= cfg_len;
      lfsr_seed <= (cfg_seed == '0) ? SEED_W'(SEED_NONZERO) : cfg_seed;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_count <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
    end else if (accept) begin
      sym_count <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (state == PAY && dp_valid && sym_count != len_q) sym_count <= sym_count + 1'b1;
      if (wd_expired) timeout <= 1'b1;
      if (abort_live) aborted <= 1'b1;
    end
  end

  assign lfsr_load    = (state == LOAD);
  assign dp_enable    = (state == PRE) || (state == PAY);
  assign sel_preamble = (state == PRE);
  assign dp_flush     = (state == FLUSH);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_qam_frame_scheduler.sv
// Directed bench for qam_frame_scheduler: nominal, zero seed/length, stall,
// abort, back-to-back and mid-frame reset scenarios with hand-computed timing.
module tb_qam_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [6:0] cfg_seed;
  logic [9:0] cfg_len;
  logic       dp_valid;
  logic [6:0] lfsr_seed;
  logic       lfsr_load;
  logic       dp_enable;
  logic       sel_preamble;
  logic       dp_flush;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       aborted;
  logic [9:0] sym_count;

  int checks = 0;
  int errors = 0;

  int cyc, load_n, pre_n, pay_n, flush_n, done_cyc, first_to_cyc, first_ab_cyc;

  qam_frame_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cfg_seed     (cfg_seed),
    .cfg_len      (cfg_len),
    .dp_valid     (dp_valid),
    .lfsr_seed    (lfsr_seed),
    .lfsr_load    (lfsr_load),
    .dp_enable    (dp_enable),
    .sel_preamble (sel_preamble),
    .dp_flush     (dp_flush),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .aborted      (aborted),
    .sym_count    (sym_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({lfsr_seed, lfsr_load, dp_enable, sel_preamble, dp_flush,
                busy, done, timeout, aborted, sym_count});
  endfunction

  // Called in an IDLE cycle; returns sampling the LOAD cycle.
  task automatic start_frame(input logic [6:0] seed, input logic [9:0] len);
    cfg_seed = seed;
    cfg_len  = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Cycle 1 is the LOAD cycle. dp_valid is offered in PAY until valid_max
  // symbols have been delivered. Stops at done or at stop_cyc (if nonzero).
  task automatic run_frame(input int valid_max, input int abort_cyc, input int start_cyc,
                           input bit hold_start, input int stop_cyc);
    int valid_left;
    valid_left   = valid_max;
    cyc          = 1;
    load_n       = 0;
    pre_n        = 0;
    pay_n        = 0;
    flush_n      = 0;
    done_cyc     = 0;
    first_to_cyc = 0;
    first_ab_cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (lfsr_load) load_n++;
      if (sel_preamble) pre_n++;
      if (dp_enable && !sel_preamble) pay_n++;
      if (dp_flush) flush_n++;
      if (timeout && first_to_cyc == 0) first_to_cyc = cyc;
      if (aborted && first_ab_cyc == 0) first_ab_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stop_cyc == cyc) break;
      dp_valid = dp_enable && !sel_preamble && (valid_left > 0);
      if (dp_valid) valid_left--;
      abort = (cyc == abort_cyc);
      start = hold_start || (cyc == start_cyc);
      tick();
      cyc++;
    end
    dp_valid = 1'b0;
    abort    = 1'b0;
    start    = hold_start;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_seed = '0;
    cfg_len  = '0;
    dp_valid = 1'b0;
    #1;
    check("por_outputs", all_outputs(), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal frame: 1 + 8 + 32 + 4 + 1 = 46 cycles.
    start_frame(7'h55, 10'd32);
    check("nom_load", 32'(lfsr_load), 32'd1);
    check("nom_seed", 32'(lfsr_seed), 32'h55);
    check("nom_busy", 32'(busy), 32'd1);
    run_frame(1000, 0, 0, 1'b0, 0);
    check("nom_done_cyc", 32'(done_cyc), 32'd46);
    check("nom_load_n", 32'(load_n), 32'd1);
    check("nom_pre_n", 32'(pre_n), 32'd8);
    check("nom_pay_n", 32'(pay_n), 32'd32);
    check("nom_flush_n", 32'(flush_n), 32'd4);
    check("nom_sym", 32'(sym_count), 32'd32);
    check("nom_flags", 32'({timeout, aborted}), 32'd0);
    tick();
    check("nom_post_done", 32'({busy, done}), 32'd0);
    check("nom_sym_hold", 32'(sym_count), 32'd32);

    // Zero seed becomes 1; zero length skips PAY: 1 + 8 + 4 + 1 = 14.
    start_frame(7'h00, 10'd0);
    check("zero_seed", 32'(lfsr_seed), 32'h01);
    check("zero_sym_clr", 32'(sym_count), 32'd0);
    run_frame(1000, 0, 0, 1'b0, 0);
    check("zero_done_cyc", 32'(done_cyc), 32'd14);
    check("zero_pay_n", 32'(pay_n), 32'd0);
    check("zero_flush_n", 32'(flush_n), 32'd4);
    check("zero_sym", 32'(sym_count), 32'd0);
    tick();

    // Stall: PAY cycles 10..12 valid, 16 idle cycles 13..28, FLUSH from 29, done at 33.
    start_frame(7'h0F, 10'd10);
    run_frame(3, 0, 0, 1'b0, 0);
    check("stall_to_cyc", 32'(first_to_cyc), 32'd29);
    check("stall_done_cyc", 32'(done_cyc), 32'd33);
    check("stall_pay_n", 32'(pay_n), 32'd19);
    check("stall_sym", 32'(sym_count), 32'd3);
    check("stall_flags", 32'({timeout, aborted}), 32'b10);
    tick();

    // Abort on the 5th payload symbol (cycle 14); start during FLUSH is ignored.
    start_frame(7'h3C, 10'd20);
    check("abort_to_clr", 32'(timeout), 32'd0);
    cfg_seed = 7'h7F;
    run_frame(1000, 14, 16, 1'b0, 0);
    check("abort_ab_cyc", 32'(first_ab_cyc), 32'd15);
    check("abort_done_cyc", 32'(done_cyc), 32'd19);
    check("abort_sym", 32'(sym_count), 32'd5);
    check("abort_flags", 32'({timeout, aborted}), 32'b01);
    tick();
    check("abort_ignored_start", 32'({busy, lfsr_load}), 32'd0);
    check("abort_seed_hold", 32'(lfsr_seed), 32'h3C);

    // Back-to-back with start held: 1 + 8 + 2 + 4 + 1 = 16, then IDLE, then LOAD.
    start = 1'b1;
    start_frame(7'h2A, 10'd2);
    check("b2b_ab_clr", 32'(aborted), 32'd0);
    run_frame(1000, 0, 0, 1'b1, 0);
    check("b2b_done_cyc", 32'(done_cyc), 32'd16);
    check("b2b_seed_hold", 32'(lfsr_seed), 32'h2A);
    cfg_seed = 7'h13;
    cfg_len  = 10'd1;
    tick();
    check("b2b_gap_idle", 32'({busy, done}), 32'd0);
    tick();
    start = 1'b0;
    check("b2b_load2", 32'(lfsr_load), 32'd1);
    check("b2b_seed2", 32'(lfsr_seed), 32'h13);
    check("b2b_sym_clr", 32'(sym_count), 32'd0);
    run_frame(1000, 0, 0, 1'b0, 0);
    check("b2b2_done_cyc", 32'(done_cyc), 32'd15);
    check("b2b2_sym", 32'(sym_count), 32'd1);
    tick();

    // Reset during PAY: outputs clear asynchronously, no done, back to IDLE.
    start_frame(7'h11, 10'd50);
    run_frame(1000, 0, 0, 1'b0, 15);
    check("rst_in_pay", 32'({dp_enable, sel_preamble}), 32'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", all_outputs(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    tick();
    tick();
    check("rst_idle", 32'({busy, done, lfsr_load}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
